sbox_array_pipe: RTL and testbench

Parametrised, pipelined AES S-box array: `LANES` independent byte lanes substituted in parallel through a fixed 3-stage composite-field (GF((2^4)^2)) datapath, with valid/ready flow control and optional per-transaction inverse mode. It serves as the SubBytes/InvSubBytes engine and the key-schedule SubWord engine for the AES round datapath, replacing single-byte, free-running S-box instances.

---
 rtl/sbox_array_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_sbox_array_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_array_pipe.sv
// LANES-wide pipelined AES S-box (GF((2^4)^2) datapath) with valid/ready flow control.
// Define SBOX_INV_EN to compile in the per-transaction inverse S-box mode.
module sbox_array_pipe #(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic               out_valid,
    input  logic               out_ready
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] frob16(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 4; i++) r = gf_mul(r, r);
        return r;
    endfunction

    function automatic logic [7:0] sub_img(input logic [7:0] x, input logic [3:0] v);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = 8'h01;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = r ^ p;
            p = gf_mul(p, x);
        end
        return r;
    endfunction

    // Locate X (root of x^4+x+1), then the first lambda making y^2+y+lambda irreducible
    // over GF(16) together with one of its roots Y; returns {lambda, Y, X}.
    function automatic logic [19:0] calc_field();
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] t;
        logic [7:0] sq;
        logic [7:0] limg;
        logic [7:0] r;
        logic [3:0] lam;
        x = 8'h00;
        y = 8'h00;
        lam = 4'h0;
        for (int i = 2; i < 256 && x == 8'h00; i++) begin
            t = 8'(i);
            sq = gf_mul(t, t);
            if ((gf_mul(sq, sq) ^ t ^ 8'h01) == 8'h00) x = t;
        end
        for (int l = 1; l < 16 && y == 8'h00; l++) begin
            limg = sub_img(x, 4'(l));
            r = 8'h00;
            for (int i = 1; i < 256 && r == 8'h00; i++) begin
                t = 8'(i);
                if ((gf_mul(t, t) ^ t ^ limg) == 8'h00) r = t;
            end
            if (r != 8'h00 && frob16(r) != r) begin
                y = r;
                lam = 4'(l);
            end
        end
        return {lam, y, x};
    endfunction

    function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = r ^ m[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] calc_c2b(input logic [7:0] x, input logic [7:0] y);
        logic [63:0] cols;
        logic [7:0]  p;
        p = 8'h01;
        cols = '0;
        for (int j = 0; j < 4; j++) begin
            cols[8*j +: 8]     = p;
            cols[8*(j+4) +: 8] = gf_mul(p, y);
            p = gf_mul(p, x);
        end
        return cols;
    endfunction

    function automatic logic [63:0] calc_b2c(input logic [63:0] m);
        logic [63:0] cols;
        logic        found;
        cols = '0;
        for (int k = 0; k < 8; k++) begin
            found = 1'b0;
            for (int c = 0; c < 256 && !found; c++) begin
                if (lin_map(m, 8'(c)) == 8'(1 << k)) begin
                    cols[8*k +: 8] = 8'(c);
                    found = 1'b1;
                end
            end
        end
        return cols;
    endfunction

    localparam logic [19:0] FieldCfg  = calc_field();
    localparam logic [3:0]  Lam       = FieldCfg[19:16];
    localparam logic [63:0] CompToBin = calc_c2b(FieldCfg[7:0], FieldCfg[15:8]);
    localparam logic [63:0] BinToComp = calc_b2c(CompToBin);

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] s;
        p = 4'h0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // a^14 = a^-1, and maps 0 to 0
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2;
        logic [3:0] a4;
        logic [3:0] a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a2, a4), a8);
    endfunction

    function automatic logic [7:0] comp_inv(input logic [7:0] c);
        logic [3:0] d;
        logic [3:0] di;
        d  = gf16_mul(gf16_mul(c[7:4], c[7:4]), Lam) ^ gf16_mul(c[7:4], c[3:0]) ^
             gf16_mul(c[3:0], c[3:0]);
        di = gf16_inv(d);
        return {gf16_mul(c[7:4], di), gf16_mul(c[3:0] ^ c[7:4], di)};
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^
               8'h63;
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction
`endif

    logic               adv;
    logic               mode_in;
    logic [8*LANES-1:0] s1_d, s2_d, s3_d;
    logic [8*LANES-1:0] s1_data_q, s2_data_q, s3_data_q;
    logic               s1_valid_q, s2_valid_q, s3_valid_q;
    logic               s1_inv_q, s2_inv_q, s3_inv_q;

`ifdef SBOX_INV_EN
    assign mode_in = in_inv;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign mode_in       = 1'b0;
`endif

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_data  = s3_data_q;
    assign out_inv   = s3_inv_q;
    assign out_valid = s3_valid_q;

    always_comb begin
        s1_d = '0;
        s2_d = '0;
        s3_d = '0;
        for (int i = 0; i < int'(LANES); i++) begin
`ifdef SBOX_INV_EN
            s1_d[8*i +: 8] = lin_map(BinToComp,
                                     mode_in ? aff_inv(in_data[8*i +: 8]) : in_data[8*i +: 8]);
            s3_d[8*i +: 8] = s2_inv_q ? lin_map(CompToBin, s2_data_q[8*i +: 8]) :
                                        aff_fwd(lin_map(CompToBin, s2_data_q[8*i +: 8]));
`else
            s1_d[8*i +: 8] = lin_map(BinToComp, in_data[8*i +: 8]);
            s3_d[8*i +: 8] = aff_fwd(lin_map(CompToBin, s2_data_q[8*i +: 8]));
`endif
            s2_d[8*i +: 8] = comp_inv(s1_data_q[8*i +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_inv_q   <= 1'b0;
            s2_inv_q   <= 1'b0;
            s3_inv_q   <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
            s3_data_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s1_inv_q   <= mode_in;
            s2_inv_q   <= s1_inv_q;
            s3_inv_q   <= s2_inv_q;
            s1_data_q  <= s1_d;
            s2_data_q  <= s2_d;
            s3_data_q  <= s3_d;
        end
    end

endmodule

// File: tb/tb_sbox_array_pipe.sv
// Scoreboard bench for sbox_array_pipe (LANES = 4); honours SBOX_INV_EN when defined.
module tb_sbox_array_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_inv;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_inv;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    typedef struct packed {
        logic [31:0] data;
        logic        inv;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    sbox_array_pipe #(.LANES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_inv   (in_inv),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_inv  (out_inv),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic eff_inv(input logic inv);
`ifdef SBOX_INV_EN
        return inv;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = eff_inv(inv) ? isbox_t[d[8*i +: 8]] : sbox_t[d[8*i +: 8]];
        return r;
    endfunction

    // Output consume and input accept are both decided by the levels seen mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_occupancy", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", 64'(out_data), 64'(mon_e.data));
                    check("sb_inv", 64'(out_inv), 64'(mon_e.inv));
                end
            end
            if (in_valid && in_ready) sb_q.push_back({model(in_data, in_inv), eff_inv(in_inv)});
        end
    end

    task automatic send(input logic [31:0] d, input logic inv);
        logic acc;
        acc = 1'b0;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
    endtask

    // Called right after the capture edge of a lone word on an empty pipe.
    task automatic check_latency(input string tag, input logic [31:0] d, input logic inv);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({tag, "_valid"}, 64'(out_valid), 64'(k == 2));
            if (k == 2) begin
                check({tag, "_data"}, 64'(out_data), 64'(d));
                check({tag, "_inv"}, 64'(out_inv), 64'(inv));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [7:0]  inv_t [256];
        logic [7:0]  x, s;
        logic [4:0]  pat;
        logic [7:0]  ov;
        logic [31:0] w0;
        int          t0;

        inv_t[0] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv_t[a] = 8'(b);
        for (int a = 0; a < 256; a++) begin
            x = inv_t[a];
            for (int i = 0; i < 8; i++)
                s[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ ((8'h63 >> i) & 1);
            sbox_t[a]  = s;
            isbox_t[s] = 8'(a);
        end

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_inv", 64'(out_inv), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Known vector with exact latency, then full forward sweep at one word per cycle
        send(32'hFF530100, 1'b0);
        check_latency("fwd_known", 32'h16ED7C63, 1'b0);
        t0 = cyc;
        for (int v = 0; v < 64; v++)
            send({8'(4*v+3), 8'(4*v+2), 8'(4*v+1), 8'(4*v)}, 1'b0);
        check("fwd_rate", 64'(cyc - t0), 64'd64);
        drain("fwd_sweep");

        send(32'h16ED7C63, 1'b1);
`ifdef SBOX_INV_EN
        check_latency("inv_known", 32'hFF530100, 1'b1);
`else
        check_latency("inv_known", 32'h475510FB, 1'b0);
`endif
        for (int v = 0; v < 64; v++)
            send({sbox_t[4*v+3], sbox_t[4*v+2], sbox_t[4*v+1], sbox_t[4*v]}, 1'b1);
        drain("round_trip");

        send({4{8'h53}}, 1'b0);
        send({4{8'hED}}, 1'b1);
        send({4{8'h00}}, 1'b0);
        drain("mixed");

        // Backpressure: stall for 5 cycles with the pipe full and a word offered
        w0 = 32'h10203040;
        for (int k = 0; k < 3; k++) send(w0 + 32'(k) * 32'h01010101, 1'b0);
        out_ready = 1'b0;
        in_data   = w0 + 32'h03030303;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'(out_data), 64'(model(w0, 1'b0)));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int k = 3; k < 8; k++) send(w0 + 32'(k) * 32'h01010101, 1'b0);
        drain("stall");

        pat = 5'b01101;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5) ? pat[c] : 1'b0;
            in_data  = {4{8'(c + 8'hA0)}};
            @(negedge clk);
            ov[c] = out_valid;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++)
            check($sformatf("bubble_%0d", c), 64'(ov[c]), 64'((c >= 3) ? pat[c-3] : 1'b0));
        drain("bubble");

        // Reset with three words in flight; none of them may surface afterwards
        send(32'hDEADBEEF, 1'b0);
        send(32'h01234567, 1'b1);
        send(32'h89ABCDEF, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_data", 64'(out_data), 64'd0);
        check("flush_out_inv", 64'(out_inv), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(32'h0053FF01, 1'b0);
        check_latency("post_rst", 32'h63ED167C, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
